// File: rtl/multi_step_counter_ctrl_if.sv
// Bundles the config handshake, per-channel step handshake and status outputs
// of the multi-channel step counter.
interface multi_step_counter_ctrl_if #(
  parameter int NUM_CH           = 4,
  parameter int COUNTER_BITWIDTH = 8
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int W  = COUNTER_BITWIDTH;

  logic              en_i;
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [CW-1:0]     cfg_ch_i;
  logic [W-1:0]      cfg_target_i;
  logic              cfg_mode_i;
  logic [NUM_CH-1:0] step_valid_i;
  logic [NUM_CH-1:0] step_ready_o;
  logic [NUM_CH-1:0] recount_i;
  logic [NUM_CH-1:0] clr_i;
  logic [NUM_CH*W-1:0] q_o;
  logic [NUM_CH-1:0] busy_o;
  logic [NUM_CH-1:0] done_o;
  logic [NUM_CH-1:0] done_pulse_o;
  logic [NUM_CH-1:0] overflow_o;

  modport master (
    output en_i, cfg_valid_i, cfg_ch_i, cfg_target_i, cfg_mode_i,
           step_valid_i, recount_i, clr_i,
    input  cfg_ready_o, step_ready_o, q_o, busy_o, done_o, done_pulse_o, overflow_o
  );

  modport slave (
    input  en_i, cfg_valid_i, cfg_ch_i, cfg_target_i, cfg_mode_i,
           step_valid_i, recount_i, clr_i,
    output cfg_ready_o, step_ready_o, q_o, busy_o, done_o, done_pulse_o, overflow_o
  );
endinterface

// File: rtl/multi_step_counter_ctrl.sv
// Multi-channel step counter: each channel counts accepted steps up to a
// programmable target and reports terminal events (sticky, pulse, overflow).
module multi_step_counter_ctrl #(
  parameter int NUM_CH           = 4,
  parameter int COUNTER_BITWIDTH = 8,
  parameter int PIPES            = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  multi_step_counter_ctrl_if.slave bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int W  = COUNTER_BITWIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} ch_state_t;

  logic [NUM_CH-1:0] cfg_sel;
  logic [NUM_CH-1:0] run_vec;
  logic [NUM_CH-1:0] cfg_load;
  logic [NUM_CH-1:0] step_ready;
  logic [NUM_CH-1:0] terminal;
  logic              cfg_ready;
  logic              cfg_accept;

  // An out-of-range channel selects nobody, so it is always ready and dropped.
  assign cfg_ready       = ~|(cfg_sel & run_vec);
  assign cfg_accept      = bus.cfg_valid_i & cfg_ready;
  assign bus.cfg_ready_o = cfg_ready;
  assign bus.step_ready_o = step_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t  state_reg, state_next;
      logic [W-1:0] q_reg, q_next;
      logic [W-1:0] target_reg, target_next;
      logic       mode_reg, mode_next;
      logic       done_reg, done_next;
      logic       ovf_reg, ovf_next;
      logic       step_acc;

      assign cfg_sel[gi]    = (bus.cfg_ch_i == CW'(gi));
      assign run_vec[gi]    = (state_reg == ST_RUN);
      assign cfg_load[gi]   = cfg_accept & cfg_sel[gi];
      assign step_ready[gi] = bus.en_i & run_vec[gi] & ~bus.recount_i[gi] & ~cfg_load[gi];
      assign step_acc       = bus.step_valid_i[gi] & step_ready[gi];
      // Target 0 wraps to all-ones here, which gives the 2^W-step period.
      assign terminal[gi]   = step_acc & (q_reg == target_reg - W'(1));

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_reg  <= ST_IDLE;
          q_reg      <= '0;
          target_reg <= '0;
          mode_reg   <= 1'b0;
          done_reg   <= 1'b0;
          ovf_reg    <= 1'b0;
        end else begin
          state_reg  <= state_next;
          q_reg      <= q_next;
          target_reg <= target_next;
          mode_reg   <= mode_next;
          done_reg   <= done_next;
          ovf_reg    <= ovf_next;
        end
      end

      always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
        target_next = target_reg;
        mode_next   = mode_reg;
        done_next   = done_reg;
        ovf_next    = ovf_reg;

        if (cfg_load[gi]) begin
          target_next = bus.cfg_target_i;
          mode_next   = bus.cfg_mode_i;
          q_next      = '0;
          state_next  = ST_RUN;
          done_next   = 1'b0;
          ovf_next    = 1'b0;
        end else if (bus.recount_i[gi]) begin
          q_next = '0;
          if (state_reg == ST_DONE) begin
            state_next = ST_RUN;
          end
        end else if (terminal[gi]) begin
          done_next = 1'b1;
          ovf_next  = bus.clr_i[gi] ? 1'b0 : (ovf_reg | done_reg);
          if (mode_reg) begin
            q_next = '0;
          end else begin
            q_next     = target_reg;
            state_next = ST_DONE;
          end
        end else if (step_acc) begin
          q_next = q_reg + W'(1);
        end

        // A terminal in the same cycle keeps done set over a clear.
        if (bus.clr_i[gi] && !terminal[gi]) begin
          done_next = 1'b0;
          ovf_next  = 1'b0;
        end
      end

      assign bus.q_o[gi*W +: W]  = q_reg;
      assign bus.busy_o[gi]      = run_vec[gi];
      assign bus.done_o[gi]      = done_reg;
      assign bus.overflow_o[gi]  = ovf_reg;
    end
  endgenerate

  // Stage 0 rises with done; the output taps the last of PIPES+1 stages.
  logic [PIPES:0][NUM_CH-1:0] pulse_pipe_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pulse_pipe_reg <= '0;
    end else begin
      pulse_pipe_reg[0] <= terminal;
      for (int s = 1; s <= PIPES; s++) begin
        pulse_pipe_reg[s] <= pulse_pipe_reg[s-1];
      end
    end
  end

  assign bus.done_pulse_o = pulse_pipe_reg[PIPES];
endmodule

// File: tb/tb_multi_step_counter_ctrl.sv
// Scoreboard bench: a behavioural model predicts readies and post-edge status;
// a monitor process pops the predictions and compares them against the DUT.
module tb_multi_step_counter_ctrl;
  localparam int NUM_CH = 5;
  localparam int W      = 4;
  localparam int PIPES  = 2;
  localparam int CW     = 3;

  typedef struct {
    logic              cfg_ready;
    logic [NUM_CH-1:0] step_ready;
  } comb_exp_t;

  typedef struct {
    logic [NUM_CH*W-1:0] q;
    logic [NUM_CH-1:0]   busy;
    logic [NUM_CH-1:0]   done;
    logic [NUM_CH-1:0]   ovf;
    logic [NUM_CH-1:0]   pulse;
  } reg_exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  multi_step_counter_ctrl_if #(.NUM_CH(NUM_CH), .COUNTER_BITWIDTH(W)) bus ();

  multi_step_counter_ctrl #(
    .NUM_CH(NUM_CH), .COUNTER_BITWIDTH(W), .PIPES(PIPES)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus for the next cycle
  logic              d_rst, d_en, d_cfg_valid, d_mode;
  logic [CW-1:0]     d_ch;
  logic [W-1:0]      d_tgt;
  logic [NUM_CH-1:0] d_sv, d_rc, d_clr;

  // behavioural model: step counts as plain integers
  int m_cnt [NUM_CH];
  int m_tgt [NUM_CH];
  bit m_auto[NUM_CH];
  bit m_running[NUM_CH];
  bit m_finished[NUM_CH];
  bit m_done[NUM_CH];
  bit m_ovf[NUM_CH];
  logic [NUM_CH-1:0] pulse_hist[$];

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_tgt[c] = 0; m_auto[c] = 0;
      m_running[c] = 0; m_finished[c] = 0; m_done[c] = 0; m_ovf[c] = 0;
    end
    pulse_hist.delete();
    for (int s = 0; s < PIPES; s++) pulse_hist.push_back('0);
  endtask

  task automatic tick();
    comb_exp_t ce;
    reg_exp_t  re;
    logic [NUM_CH-1:0] term;
    int ch;
    int need;
    bit load;
    @(negedge clk);
    cyc++;
    rst                = d_rst;
    bus.en_i           = d_en;
    bus.cfg_valid_i    = d_cfg_valid;
    bus.cfg_ch_i       = d_ch;
    bus.cfg_target_i   = d_tgt;
    bus.cfg_mode_i     = d_mode;
    bus.step_valid_i   = d_sv;
    bus.recount_i      = d_rc;
    bus.clr_i          = d_clr;
    $display("cyc %0d rst=%0b en=%0b cfg=%0b ch=%0d tgt=%0d mode=%0b step=%b rc=%b clr=%b",
             cyc, d_rst, d_en, d_cfg_valid, d_ch, d_tgt, d_mode, d_sv, d_rc, d_clr);

    ch = int'(d_ch);
    ce.cfg_ready = (ch >= NUM_CH) ? 1'b1 : !m_running[ch];
    for (int c = 0; c < NUM_CH; c++) begin
      load = d_cfg_valid && ce.cfg_ready && (ch == c);
      ce.step_ready[c] = d_en && m_running[c] && !d_rc[c] && !load;
    end
    comb_q.push_back(ce);

    term = '0;
    if (d_rst) begin
      model_reset();
      re.pulse = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        load = d_cfg_valid && ce.cfg_ready && (ch == c);
        if (load) begin
          m_tgt[c] = int'(d_tgt); m_auto[c] = d_mode; m_cnt[c] = 0;
          m_running[c] = 1; m_finished[c] = 0; m_done[c] = 0; m_ovf[c] = 0;
        end else if (d_rc[c]) begin
          m_cnt[c] = 0;
          if (m_finished[c]) begin
            m_finished[c] = 0; m_running[c] = 1;
          end
        end else if (d_sv[c] && ce.step_ready[c]) begin
          need = (m_tgt[c] == 0) ? (1 << W) : m_tgt[c];
          if (m_cnt[c] + 1 == need) begin
            term[c]  = 1'b1;
            m_ovf[c] = d_clr[c] ? 1'b0 : (m_ovf[c] || m_done[c]);
            m_done[c] = 1;
            if (m_auto[c]) m_cnt[c] = 0;
            else begin
              m_cnt[c] = need; m_running[c] = 0; m_finished[c] = 1;
            end
          end else begin
            m_cnt[c]++;
          end
        end
        if (d_clr[c] && !term[c]) begin
          m_done[c] = 0; m_ovf[c] = 0;
        end
      end
      pulse_hist.push_back(term);
      re.pulse = pulse_hist.pop_front();
    end
    for (int c = 0; c < NUM_CH; c++) begin
      re.q[c*W +: W] = W'(m_cnt[c] % (1 << W));
      re.busy[c] = m_running[c];
      re.done[c] = m_done[c];
      re.ovf[c]  = m_ovf[c];
    end
    reg_q.push_back(re);

    d_rst = 0; d_cfg_valid = 0; d_sv = '0; d_rc = '0; d_clr = '0;
  endtask

  // monitor: readies just after inputs settle, status just after the edge
  initial begin
    comb_exp_t ce;
    reg_exp_t  re;
    forever begin
      @(negedge clk);
      #1;
      if (comb_q.size() > 0) begin
        ce = comb_q.pop_front();
        check("cfg_ready", 64'(bus.cfg_ready_o), 64'(ce.cfg_ready));
        check("step_ready", 64'(bus.step_ready_o), 64'(ce.step_ready));
      end
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        re = reg_q.pop_front();
        check("q", 64'(bus.q_o), 64'(re.q));
        check("busy", 64'(bus.busy_o), 64'(re.busy));
        check("done", 64'(bus.done_o), 64'(re.done));
        check("overflow", 64'(bus.overflow_o), 64'(re.ovf));
        check("done_pulse", 64'(bus.done_pulse_o), 64'(re.pulse));
      end
    end
  end

  task automatic cfg(input int ch, input int tgt, input bit mode);
    d_cfg_valid = 1; d_ch = CW'(ch); d_tgt = W'(tgt); d_mode = mode;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    d_rst = 0; d_en = 1; d_cfg_valid = 0; d_mode = 0;
    d_ch = '0; d_tgt = '0; d_sv = '0; d_rc = '0; d_clr = '0;
    rst = 1; bus.en_i = 0; bus.cfg_valid_i = 0; bus.cfg_ch_i = '0;
    bus.cfg_target_i = '0; bus.cfg_mode_i = 0; bus.step_valid_i = '0;
    bus.recount_i = '0; bus.clr_i = '0;
    repeat (2) @(negedge clk);
    model_reset();
    d_rst = 1; tick();
    tick();

    // one-shot target 5 on ch1, then extra refused steps, then recount
    cfg(1, 5, 0); tick();
    repeat (7) begin d_sv = 5'b00010; tick(); end
    d_rc = 5'b00010; tick();

    // auto-reload target 3 on ch2, clear alongside the third terminal
    cfg(2, 3, 1); tick();
    for (int i = 1; i <= 9; i++) begin
      d_sv = 5'b00100;
      if (i == 9) d_clr = 5'b00100;
      tick();
    end
    tick();

    // target 0 one-shot on ch3: 2^W steps, config attempts while running
    cfg(3, 0, 0); tick();
    for (int i = 1; i <= 16; i++) begin
      d_sv = 5'b01000;
      if (i == 8) cfg(3, 2, 1);
      tick();
    end
    cfg(3, 2, 1); tick();

    // recount and step together on ch0 at q=7, then en low with steps pending
    cfg(0, 10, 1); tick();
    repeat (7) begin d_sv = 5'b00001; tick(); end
    d_sv = 5'b00001; d_rc = 5'b00001; tick();
    d_sv = 5'b00001; tick();
    d_en = 0;
    repeat (3) begin d_sv = 5'b00001; tick(); end
    d_en = 1;

    // reset one cycle after a terminal drops the in-flight pulse
    cfg(4, 1, 0); tick();
    d_sv = 5'b10000; tick();
    d_rst = 1; tick();
    repeat (3) tick();

    // all channels target 2, stepped together, then an out-of-range config
    for (int c = 0; c < NUM_CH; c++) begin cfg(c, 2, 0); tick(); end
    repeat (2) begin d_sv = '1; tick(); end
    cfg(5, 7, 1); tick();
    repeat (PIPES + 1) tick();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      d_rst       = ($urandom_range(0, 99) == 0);
      d_en        = ($urandom_range(0, 7) != 0);
      d_cfg_valid = ($urandom_range(0, 3) == 0);
      d_ch        = CW'($urandom_range(0, 7));
      d_tgt       = W'($urandom_range(0, 15));
      d_mode      = 1'($urandom_range(0, 1));
      d_sv        = NUM_CH'($urandom_range(0, 31));
      for (int c = 0; c < NUM_CH; c++) begin
        d_rc[c]  = ($urandom_range(0, 15) == 0);
        d_clr[c] = ($urandom_range(0, 15) == 0);
      end
      tick();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(comb_q.size() + reg_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
